// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, 1-cycle RAM reads, show-ahead prefetch FIFO
module fetch_unit #(
  parameter int ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  decode_ready,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  inflight;
  logic [WORD_WIDTH-1:0] buf_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        occupancy;
  logic                  push;
  logic                  pop;

  // Counting the outstanding read as occupied space is what makes overflow impossible.
  always_comb begin
    occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    mem_req     = !nreset && !branch_valid && (occupancy < DEPTH_V);
    mem_addr    = fetch_pc;
    instr_valid = (count != '0);
    instr       = instr_valid ? buf_data[rd_ptr] : '0;
    instr_pc    = instr_valid ? buf_pc[rd_ptr] : '0;
    push        = inflight && !branch_valid && !nreset;
    pop         = instr_valid && decode_ready && !branch_valid && !nreset;
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_valid) begin
      fetch_pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00};
      req_pc   <= fetch_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (mem_req) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      req_pc   <= fetch_pc;
      inflight <= mem_req;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_data[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a 1-cycle instruction RAM model
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        nreset;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        branch_valid;
  logic [13:0] branch_target;
  logic        decode_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [13:0] instr_pc;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clock(clock), .nreset(nreset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .decode_ready(decode_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [13:0] a);
    return 32'hC0DE_0000 | {18'b0, a};
  endfunction

  // Unrequested cycles return junk so a stale capture would show up.
  always @(posedge clock) begin
    if (mem_req) mem_rdata <= word_of(mem_addr);
    else         mem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [13:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, "_instr"}, instr, word_of(pc));
  endtask

  initial begin
    int nreq;
    int npop;
    logic [13:0] exp_pc;
    logic [13:0] hold_pc;
    logic        holding;
    logic [15:0] pat;

    mem_rdata     = '0;
    nreset        = 1'b1;
    branch_valid  = 1'b0;
    branch_target = '0;
    decode_ready  = 1'b0;

    // 1: reset then streaming
    tick(); tick(); tick();
    #1;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    32'(instr_pc), 32'd0);
    nreset = 1'b0; decode_ready = 1'b1;
    #1;
    chk("t1_req0",  32'(mem_req), 32'd1);
    chk("t1_addr0", 32'(mem_addr), 32'h0);
    tick(); #1;
    chk("t1_addr1",  32'(mem_addr), 32'h4);
    chk("t1_valid1", 32'(instr_valid), 32'd0);
    tick(); #1;
    chk_head("t1_first", 14'h0);
    for (int k = 1; k <= 6; k++) begin
      tick(); #1;
      chk_head("t1_stream", 14'(4 * k));
    end

    // 3: branch while streaming, in-flight word dropped
    branch_valid = 1'b1; branch_target = 14'h0103;
    #1;
    chk("t3_req_n", 32'(mem_req), 32'd0);
    tick(); branch_valid = 1'b0; #1;
    chk("t3_addr",  32'(mem_addr), 32'h100);
    chk("t3_req",   32'(mem_req), 32'd1);
    chk("t3_v_n1",  32'(instr_valid), 32'd0);
    tick(); #1;
    chk("t3_v_n2",  32'(instr_valid), 32'd0);
    tick(); #1;
    chk_head("t3_tgt", 14'h100);
    tick(); #1;
    chk_head("t3_tgt1", 14'h104);

    // 5: branch near top of address space, wrap
    branch_valid = 1'b1; branch_target = 14'h3FF8;
    tick(); branch_valid = 1'b0; #1;
    chk("t5_addr", 32'(mem_addr), 32'h3FF8);
    tick(); #1;
    chk("t5_addr_wrapin", 32'(mem_addr), 32'h3FFC);
    tick(); #1;
    chk("t5_addr_wrap", 32'(mem_addr), 32'h0000);
    chk_head("t5_a", 14'h3FF8);
    tick(); #1; chk_head("t5_b", 14'h3FFC);
    tick(); #1; chk_head("t5_c", 14'h0000);
    tick(); #1; chk_head("t5_d", 14'h0004);

    // back-to-back branches: last wins
    branch_valid = 1'b1; branch_target = 14'h0200;
    tick(); branch_target = 14'h0302; #1;
    chk("bb_req", 32'(mem_req), 32'd0);
    tick(); branch_valid = 1'b0; #1;
    chk("bb_addr", 32'(mem_addr), 32'h300);
    tick(); #1;
    chk("bb_v", 32'(instr_valid), 32'd0);
    tick(); #1;
    chk_head("bb_head", 14'h300);

    // 2: decode stalled from release, exactly four requests
    nreset = 1'b1; decode_ready = 1'b0;
    tick(); nreset = 1'b0; #1;
    nreq = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_req) begin
        chk("t2_addr", 32'(mem_addr), 32'(4 * nreq));
        nreq++;
      end
      tick(); #1;
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk_head("t2_hold", 14'h0);
    decode_ready = 1'b1; #1;
    chk("t2_req_full", 32'(mem_req), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk_head("t2_drain", 14'(4 * k));
      if (k == 1) chk("t2_resume", 32'(mem_addr), 32'h10);
      tick(); #1;
    end

    // 4: irregular decode_ready, order and head stability against the RAM model
    nreset = 1'b1;
    tick(); nreset = 1'b0;
    pat = 16'b1011_0010_0111_0001;
    exp_pc = '0; npop = 0; holding = 1'b0; hold_pc = '0;
    for (int i = 0; i < 40; i++) begin
      decode_ready = pat[i % 16];
      #1;
      if (holding) chk("t4_stable", 32'(instr_pc), 32'(hold_pc));
      if (instr_valid && decode_ready) begin
        chk_head("t4_order", exp_pc);
        exp_pc = exp_pc + 14'd4;
        npop++;
      end
      holding = instr_valid && !decode_ready;
      hold_pc = instr_pc;
      tick();
    end
    chk("t4_progress", 32'(npop > 10), 32'd1);

    // 6: reset with 3 buffered plus one in flight
    nreset = 1'b1; decode_ready = 1'b0;
    tick(); nreset = 1'b0;
    tick(); tick(); tick(); tick();
    nreset = 1'b1; #1;
    chk("t6_req_rst", 32'(mem_req), 32'd0);
    tick(); #1;
    chk("t6_valid", 32'(instr_valid), 32'd0);
    chk("t6_instr", instr, 32'd0);
    chk("t6_pc",    32'(instr_pc), 32'd0);
    nreset = 1'b0; decode_ready = 1'b1; #1;
    chk("t6_addr", 32'(mem_addr), 32'h0);
    tick(); #1;
    chk("t6_v1", 32'(instr_valid), 32'd0);
    tick(); #1;
    chk_head("t6_first", 14'h0);
    tick(); #1;
    chk_head("t6_second", 14'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
